serializer_arbiter: RTL and testbench

- Shares one 8-bit parallel-load serializer (load pulse + 8 shift cycles, MSB first) among N_REQ requesters.
- Accepts bytes over per-requester valid/ready handshakes and picks a winner by round-robin.
- Sequences the serializer: one load pulse, then waits out the 8 shift cycles plus a programmable guard gap before the next frame.
- Sits between the byte producers and the serializer instance in the transmit path.

---
 rtl/ser_arb_pkg.sv | 17 +
 rtl/serializer_arbiter_rr_picker.sv | 42 ++++
 rtl/serializer_arbiter.sv | 121 ++++++++++++
 tb/tb_serializer_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the serializer arbiter.
// Optional build macro: SER_ARB_FIXED_PRIO_EN (fixed-priority picking).
package ser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam int SER_BITS = 8;
  localparam int CNT_W    = 4;
  localparam int GUARD_W  = 4;
  localparam int ID_W     = 3;

endpackage

// File: rtl/serializer_arbiter_rr_picker.sv
// Combinational winner search over the request vector.
// Round-robin from last+1; fixed lowest-index when SER_ARB_FIXED_PRIO_EN.
import ser_arb_pkg::*;

module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             vld,
  output logic [ID_W-1:0]  idx
);

`ifdef SER_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = ID_W'(i);
      end
    end
  end
`else
  // Walk backwards so the nearest slot after last is written last.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ]) begin
        vld = 1'b1;
        idx = ID_W'((int'(last) + k) % N_REQ);
      end
    end
  end
`endif

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter sequencing a shared 8-bit load/shift serializer.
// Build macro SER_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
import ser_arb_pkg::*;

module serializer_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    ser_load,
  output logic [DATA_W-1:0]       ser_data,
  output logic [2:0]              grant_id,
  output logic                    busy
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic                ser_load_q, ser_load_d;
  logic [DATA_W-1:0]   ser_data_q, ser_data_d;
  logic [CNT_W-1:0]    shift_q, shift_d;
  logic [GUARD_W-1:0]  guard_q, guard_d;
  logic                busy_q, busy_d;
  logic                pick_vld;
  logic [ID_W-1:0]     pick_idx;
  logic                accept;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req  (req_valid),
    .last (last_q),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  // Ready is suppressed under reset so no byte can slip through.
  assign accept    = !rst && (state_q == IDLE) && pick_vld;
  assign req_ready = accept ? (N_REQ'(1) << pick_idx) : '0;
  assign ser_load  = ser_load_q;
  assign ser_data  = ser_data_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q | accept;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    ser_load_d = 1'b0;
    ser_data_d = ser_data_q;
    shift_d    = shift_q;
    guard_d    = guard_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          ser_load_d = 1'b1;
          ser_data_d = req_data[pick_idx*DATA_W +: DATA_W];
          grant_d    = pick_idx;
`ifndef SER_ARB_FIXED_PRIO_EN
          last_d     = pick_idx;
`endif
          busy_d     = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        shift_d = CNT_W'(SER_BITS);
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = shift_q - CNT_W'(1);
        if (shift_q <= CNT_W'(1)) begin
          if (GUARD_CYCLES == 0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            guard_d = GUARD_W'(GUARD_CYCLES);
            state_d = GUARD;
          end
        end
      end
      GUARD: begin
        guard_d = guard_q - GUARD_W'(1);
        if (guard_q <= GUARD_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      grant_q    <= '0;
      ser_load_q <= 1'b0;
      ser_data_q <= '0;
      shift_q    <= '0;
      guard_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ser_load_q <= ser_load_d;
      ser_data_q <= ser_data_d;
      shift_q    <= shift_d;
      guard_q    <= guard_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_serializer_arbiter.sv
// Scoreboard bench for serializer_arbiter (N_REQ=4, GUARD_CYCLES=1).
// Build with SER_ARB_FIXED_PRIO_EN to exercise fixed priority.
module tb_serializer_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int G = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           ser_load;
  logic [W-1:0]   ser_data;
  logic [2:0]     grant_id;
  logic           busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   loads[$];

  serializer_arbiter #(
    .N_REQ        (N),
    .DATA_W       (W),
    .GUARD_CYCLES (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ser_load  (ser_load),
    .ser_data  (ser_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every load pulse is matched against the expected frame queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ser_load) begin
      loads.push_back(cyc);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL load_unexpected: got id=%0d data=%h, required no load",
                 grant_id, ser_data);
      end else begin
        e = sb.pop_front();
        n_total++;
        if (grant_id !== e.id)
          $display("FAIL frame_id: got %0d, required %0d", grant_id, e.id);
        else n_pass++;
        n_total++;
        if (ser_data !== e.data)
          $display("FAIL frame_data: got %h, required %h", ser_data, e.data);
        else n_pass++;
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    loads.delete();
  endtask

  task automatic wait_loads(input int k, input int budget, input string nm);
    for (int c = 0; c < budget && loads.size() < k; c++) begin
      @(negedge clk); #1;
    end
    n_total++;
    if (loads.size() < k)
      $display("FAIL %s_timeout: got %0d loads, required %0d", nm, loads.size(), k);
    else n_pass++;
  endtask

  task automatic wait_idle_and_drain(input string nm);
    for (int c = 0; c < 60 && busy; c++) begin
      @(negedge clk); #1;
    end
    n_total++;
    if (busy !== 1'b0 || sb.size() != 0)
      $display("FAIL %s_drain: got busy=%b pending=%0d, required busy=0 pending=0",
               nm, busy, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk); #1;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b, required 0000", req_ready);
    else n_pass++;
    n_total++;
    if (ser_load !== 1'b0) $display("FAIL rst_load: got %b, required 0", ser_load);
    else n_pass++;
    n_total++;
    if (ser_data !== 8'h00) $display("FAIL rst_data: got %h, required 00", ser_data);
    else n_pass++;
    n_total++;
    if (grant_id !== 3'd0) $display("FAIL rst_grant: got %0d, required 0", grant_id);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int acc;
    int n;
    reset_dut();
    @(posedge clk); #1;
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    sb.push_back('{3'd0, 8'hA5});
    @(negedge clk); #1;
    acc = cyc;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b, required 0001", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk); #1;
    n = 1;
    while (busy && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    n_total++;
    if (n != 11 + G - 1) $display("FAIL single_busy_len: got %0d, required %0d", n, 10 + G);
    else n_pass++;
    n_total++;
    if (loads.size() != 1 || loads[0] != acc + 1)
      $display("FAIL single_latency: got %0d loads first at %0d, required 1 at %0d",
               loads.size(), (loads.size() > 0) ? loads[0] : -1, acc + 1);
    else n_pass++;
    wait_idle_and_drain("single");
  endtask

  task automatic test_rr_all();
    reset_dut();
    @(posedge clk); #1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    sb.push_back('{3'd0, 8'h11});
    sb.push_back('{3'd1, 8'h22});
    sb.push_back('{3'd2, 8'h33});
    sb.push_back('{3'd3, 8'h44});
    sb.push_back('{3'd0, 8'h11});
    wait_loads(5, 200, "rr_all");
    req_valid = '0;
    if (loads.size() >= 5) begin
      for (int i = 1; i < 5; i++) begin
        n_total++;
        if (loads[i] - loads[i-1] != 10 + G)
          $display("FAIL rr_period%0d: got %0d, required %0d",
                   i, loads[i] - loads[i-1], 10 + G);
        else n_pass++;
      end
    end
    wait_idle_and_drain("rr_all");
  endtask

  task automatic test_mid_join();
    reset_dut();
    @(posedge clk); #1;
    req_data[23:16] = 8'h5C;
    req_valid = 4'b0100;
    sb.push_back('{3'd2, 8'h5C});
    wait_loads(1, 40, "join_first");
    repeat (3) @(posedge clk);
    #1;
    req_data[7:0] = 8'h0D;
    req_valid = 4'b0101;
    sb.push_back('{3'd0, 8'h0D});
    sb.push_back('{3'd2, 8'h5C});
    sb.push_back('{3'd0, 8'h0D});
    wait_loads(4, 200, "join");
    req_valid = '0;
    wait_idle_and_drain("join");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    @(posedge clk); #1;
    req_data[7:0] = 8'h99;
    req_valid = 4'b0001;
    sb.push_back('{3'd0, 8'h99});
    @(negedge clk); #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL rmid_ready0: got %b, required 0001", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    wait_loads(1, 10, "rmid_load");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    req_data[15:0] = 16'h5566;
    req_valid = 4'b0011;
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_total++;
    if ({req_ready, ser_load, busy, grant_id} !== 9'd0 || ser_data !== 8'h00)
      $display("FAIL rmid_outs: got ready=%b load=%b busy=%b id=%0d data=%h, required all 0",
               req_ready, ser_load, busy, grant_id, ser_data);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.push_back('{3'd0, 8'h66});
    @(negedge clk); #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL rmid_regrant: got %b, required 0001", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    wait_loads(2, 10, "rmid_load2");
    wait_idle_and_drain("rmid");
  endtask

  task automatic test_drop_pulse();
    reset_dut();
    @(posedge clk); #1;
    req_data[7:0] = 8'h77;
    req_valid = 4'b0001;
    sb.push_back('{3'd0, 8'h77});
    @(posedge clk); #1;
    req_valid = '0;
    wait_loads(1, 10, "pulse_load");
    repeat (2) @(posedge clk);
    #1;
    req_data[15:8] = 8'hB1;
    req_valid = 4'b0010;
    @(negedge clk); #1;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL pulse_ready: got %b, required 0000", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle_and_drain("pulse");
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (loads.size() != 1) $display("FAIL pulse_noload: got %0d loads, required 1", loads.size());
    else n_pass++;
    @(posedge clk); #1;
    req_data[7:0] = 8'hC2;
    req_valid = 4'b0011;
    sb.push_back('{3'd1, 8'hB1});
    @(negedge clk); #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL pulse_ptr: got %b, required 0010", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    wait_loads(2, 10, "pulse_load2");
    wait_idle_and_drain("pulse2");
  endtask

  task automatic test_fixed_prio();
    reset_dut();
    @(posedge clk); #1;
    req_data = {8'hE3, 8'h00, 8'h00, 8'hE0};
    req_valid = 4'b1001;
    repeat (3) sb.push_back('{3'd0, 8'hE0});
    wait_loads(3, 100, "fixed");
    req_valid = '0;
    wait_idle_and_drain("fixed");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_reset_mid();
`ifdef SER_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_rr_all();
    test_mid_join();
    test_drop_pulse();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
